// File: rtl/cursor_overlay_pipe.sv
// rtl/cursor_overlay_pipe.sv - two-stage arrow/crosshair cursor overlay with frame-latched position and mode hysteresis
// Optional blinking scope cursor when CURSOR_BLINK_EN is defined.
module cursor_overlay_pipe #(
   parameter int HC_W         = 11,
   parameter int VC_W         = 10,
   parameter int POS_W        = 12,
   parameter int RGB_W        = 12,
   parameter int ARROW_K      = 12,
   parameter int SCOPE_GAP    = 1,
   parameter int SCOPE_ARM    = 3,
   parameter int SCOPE_XLIMIT = 600,
   parameter int HOLD_FRAMES  = 2,
`ifdef CURSOR_BLINK_EN
   parameter int BLINK_FRAMES = 30,
`endif
   parameter logic [RGB_W-1:0] OUTLINE_RGB = 12'h000,
   parameter logic [RGB_W-1:0] FILL_RGB    = 12'hFFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [POS_W-1:0] xpos,
   input  logic [POS_W-1:0] ypos,
   input  logic             select_mode,
   input  logic [HC_W-1:0]  hcount,
   input  logic [VC_W-1:0]  vcount,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             hblnk,
   input  logic             vblnk,
   input  logic [RGB_W-1:0] rgb_in,
   output logic [HC_W-1:0]  hcount_out,
   output logic [VC_W-1:0]  vcount_out,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic             hblnk_out,
   output logic             vblnk_out,
   output logic [RGB_W-1:0] rgb_out,
   output logic             scope_active
);

   typedef enum logic [1:0] {MOUSE, ARMING, SCOPE, DISARMING} mode_t;

   localparam logic [POS_W-1:0]    XLIM = POS_W'(SCOPE_XLIMIT);
   localparam logic [3:0]          HOLD = 4'(HOLD_FRAMES);
   localparam logic signed [POS_W:0] K_S   = (POS_W+1)'(ARROW_K);
   localparam logic signed [POS_W:0] GAP_S = (POS_W+1)'(SCOPE_GAP);
   localparam logic signed [POS_W:0] END_S = (POS_W+1)'(SCOPE_GAP + SCOPE_ARM);

   mode_t            state;
   logic [3:0]       cnt;
   logic [POS_W-1:0] x_l, y_l;
   logic             vblnk_prev;
   logic             tick, req, draw_scope, show_scope;

   assign tick       = vblnk & ~vblnk_prev;
   assign req        = select_mode && (xpos < XLIM);
   assign draw_scope = (state == SCOPE) || (state == DISARMING);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= MOUSE;
         cnt          <= '0;
         x_l          <= '0;
         y_l          <= '0;
         vblnk_prev   <= 1'b0;
         scope_active <= 1'b0;
      end else begin
         vblnk_prev <= vblnk;
         if (tick) begin
            x_l <= xpos;
            y_l <= ypos;
            case (state)
               MOUSE: if (req) begin
                  if (HOLD == 4'd1) begin
                     state        <= SCOPE;
                     cnt          <= '0;
                     scope_active <= 1'b1;
                  end else begin
                     state <= ARMING;
                     cnt   <= 4'd1;
                  end
               end
               ARMING: if (!req) begin
                  state <= MOUSE;
                  cnt   <= '0;
               end else if (cnt + 4'd1 == HOLD) begin
                  state        <= SCOPE;
                  cnt          <= '0;
                  scope_active <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
               SCOPE: if (!req) begin
                  if (HOLD == 4'd1) begin
                     state        <= MOUSE;
                     cnt          <= '0;
                     scope_active <= 1'b0;
                  end else begin
                     state <= DISARMING;
                     cnt   <= 4'd1;
                  end
               end
               DISARMING: if (req) begin
                  state <= SCOPE;
                  cnt   <= '0;
               end else if (cnt + 4'd1 == HOLD) begin
                  state        <= MOUSE;
                  cnt          <= '0;
                  scope_active <= 1'b0;
               end else begin
                  cnt <= cnt + 4'd1;
               end
               default: state <= MOUSE;
            endcase
         end
      end
   end

`ifdef CURSOR_BLINK_EN
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   logic [BW-1:0] blink_cnt;
   logic          visible;

   always_ff @(posedge clk) begin
      if (!rst) begin
         blink_cnt <= '0;
         visible   <= 1'b1;
      end else if (tick) begin
         if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            visible   <= ~visible;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end
   assign show_scope = visible;
`else
   assign show_scope = 1'b1;
`endif

   // Stage 1: offsets from the latched cursor, kept signed so left/up of the cursor stays negative
   logic signed [POS_W:0] dx, dy;
   logic [HC_W-1:0]       hcount_d1;
   logic [VC_W-1:0]       vcount_d1;
   logic                  hsync_d1, vsync_d1, hblnk_d1, vblnk_d1;
   logic [RGB_W-1:0]      rgb_d1;
   logic                  scope_d1, hide_d1, valid_d1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         dx        <= '0;
         dy        <= '0;
         hcount_d1 <= '0;
         vcount_d1 <= '0;
         hsync_d1  <= 1'b0;
         vsync_d1  <= 1'b0;
         hblnk_d1  <= 1'b0;
         vblnk_d1  <= 1'b0;
         rgb_d1    <= '0;
         scope_d1  <= 1'b0;
         hide_d1   <= 1'b0;
         valid_d1  <= 1'b0;
      end else begin
         dx        <= $signed((POS_W+1)'(hcount)) - $signed({1'b0, x_l});
         dy        <= $signed((POS_W+1)'(vcount)) - $signed({1'b0, y_l});
         hcount_d1 <= hcount;
         vcount_d1 <= vcount;
         hsync_d1  <= hsync;
         vsync_d1  <= vsync;
         hblnk_d1  <= hblnk;
         vblnk_d1  <= vblnk;
         rgb_d1    <= rgb_in;
         scope_d1  <= draw_scope;
         hide_d1   <= draw_scope & ~show_scope;
         valid_d1  <= 1'b1;
      end
   end

   logic signed [POS_W:0] adx, ady;
   logic                  in_arrow, arrow_edge, scope_px;
   logic [RGB_W-1:0]      pix;

   assign adx = dx[POS_W] ? -dx : dx;
   assign ady = dy[POS_W] ? -dy : dy;

   always_comb begin
      in_arrow   = !dx[POS_W] && (dy >= dx) && (dy <= K_S);
      arrow_edge = (dx == '0) || (dx == dy) || (dy == K_S);
      scope_px   = ((dx == '0) && (dy == '0)) ||
                   ((dy == '0) && (adx > GAP_S) && (adx <= END_S)) ||
                   ((dx == '0) && (ady > GAP_S) && (ady <= END_S));
      pix = rgb_d1;
      if (valid_d1) begin
         if (scope_d1) begin
            if (scope_px && !hide_d1) pix = OUTLINE_RGB;
         end else if (in_arrow) begin
            pix = arrow_edge ? OUTLINE_RGB : FILL_RGB;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= hcount_d1;
         vcount_out <= vcount_d1;
         hsync_out  <= hsync_d1;
         vsync_out  <= vsync_d1;
         hblnk_out  <= hblnk_d1;
         vblnk_out  <= vblnk_d1;
         rgb_out    <= pix;
      end
   end

endmodule

// File: tb/tb_cursor_overlay_pipe.sv
// tb/tb_cursor_overlay_pipe.sv - scoreboard bench for cursor_overlay_pipe
module tb_cursor_overlay_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] xpos, ypos;
   logic        select_mode;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync, vsync, hblnk, vblnk;
   logic [11:0] rgb_in;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;
   logic        scope_active;

   always #5 clk = ~clk;

   cursor_overlay_pipe dut (
      .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .select_mode(select_mode),
      .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
      .hblnk(hblnk), .vblnk(vblnk), .rgb_in(rgb_in),
      .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
      .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .scope_active(scope_active)
   );

   typedef struct {
      int          due;
      logic [11:0] rgb;
      logic [10:0] hc;
      logic [9:0]  vc;
      logic [3:0]  tim;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One pixel per call: compare whatever is due now, then drive the next pixel.
   task automatic step(input logic [10:0] hc, input logic [9:0] vc, input logic vb,
                       input logic push, input logic [11:0] exp_rgb, input string tag);
      exp_t e;
      @(negedge clk);
      cyc++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         chk({e.tag, "_rgb"}, 32'(rgb_out), 32'(e.rgb));
         chk({e.tag, "_hc"}, 32'(hcount_out), 32'(e.hc));
         chk({e.tag, "_vc"}, 32'(vcount_out), 32'(e.vc));
         chk({e.tag, "_tim"}, 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'(e.tim));
      end
      hcount = hc;
      vcount = vc;
      vblnk  = vb;
      hsync  = hc[0];
      vsync  = hc[1];
      hblnk  = hc[2];
      if (push) begin
         e.due = cyc + 2;
         e.rgb = exp_rgb;
         e.hc  = hc;
         e.vc  = vc;
         e.tim = {hc[0], hc[1], hc[2], vb};
         e.tag = tag;
         sb.push_back(e);
      end
   endtask

   task automatic flush();
      repeat (3) step(11'd1000, 10'd500, 1'b0, 1'b0, 12'h0, "");
   endtask

   task automatic frame(input logic [11:0] xp, input logic [11:0] yp, input logic sel);
      xpos = xp;
      ypos = yp;
      select_mode = sel;
      step(11'd1000, 10'd500, 1'b0, 1'b0, 12'h0, "");
      step(11'd1000, 10'd500, 1'b1, 1'b0, 12'h0, "");
      step(11'd1000, 10'd500, 1'b0, 1'b0, 12'h0, "");
   endtask

   initial begin
      rst = 1'b0; xpos = '0; ypos = '0; select_mode = 1'b0;
      hcount = '0; vcount = '0; hsync = 1'b1; vsync = 1'b1; hblnk = 1'b1; vblnk = 1'b0;
      rgb_in = 12'h5A5;
      repeat (3) @(negedge clk);
      chk("reset_rgb", 32'(rgb_out), 32'h0);
      chk("reset_hc", 32'(hcount_out), 32'h0);
      chk("reset_tim", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
      chk("reset_scope", 32'(scope_active), 32'h0);
      rst = 1'b1;

      // arrow at (100,50)
      frame(12'd100, 12'd50, 1'b0);
      chk("arrow_mode", 32'(scope_active), 32'h0);
      step(11'd100, 10'd50, 1'b0, 1'b1, 12'h000, "arrow_tip");
      step(11'd105, 10'd60, 1'b0, 1'b1, 12'hFFF, "arrow_fill");
      step(11'd112, 10'd62, 1'b0, 1'b1, 12'h000, "arrow_base");
      step(11'd99,  10'd50, 1'b0, 1'b1, 12'h5A5, "arrow_left");
      step(11'd101, 10'd50, 1'b0, 1'b1, 12'h5A5, "arrow_right");
      step(11'd100, 10'd49, 1'b0, 1'b1, 12'h5A5, "arrow_above");
      flush();

      // mid-frame move ignored until the next tick
      xpos = 12'd400;
      step(11'd100, 10'd50, 1'b0, 1'b1, 12'h000, "move_old");
      step(11'd400, 10'd50, 1'b0, 1'b1, 12'h5A5, "move_early");
      flush();
      frame(12'd400, 12'd50, 1'b0);
      step(11'd400, 10'd50, 1'b0, 1'b1, 12'h000, "move_new");
      step(11'd100, 10'd50, 1'b0, 1'b1, 12'h5A5, "move_gone");
      flush();

      // hysteresis with HOLD_FRAMES=2
      frame(12'd300, 12'd50, 1'b1);
      chk("hyst_t1", 32'(scope_active), 32'h0);
      frame(12'd300, 12'd50, 1'b1);
      chk("hyst_t2", 32'(scope_active), 32'h1);
      frame(12'd300, 12'd50, 1'b0);
      chk("hyst_drop", 32'(scope_active), 32'h1);
      frame(12'd300, 12'd50, 1'b1);
      chk("hyst_restore", 32'(scope_active), 32'h1);
      frame(12'd300, 12'd50, 1'b0);
      chk("hyst_off1", 32'(scope_active), 32'h1);
      frame(12'd300, 12'd50, 1'b0);
      chk("hyst_off2", 32'(scope_active), 32'h0);

      // x limit blocks the scope request
      for (int i = 0; i < 5; i++) begin
         frame(12'd700, 12'd50, 1'b1);
         chk($sformatf("xlim_%0d", i), 32'(scope_active), 32'h0);
      end
      step(11'd700, 10'd50, 1'b0, 1'b1, 12'h000, "xlim_tip");
      step(11'd705, 10'd60, 1'b0, 1'b1, 12'hFFF, "xlim_fill");
      flush();

      // scope at the screen corner (3,3)
      frame(12'd3, 12'd3, 1'b1);
      frame(12'd3, 12'd3, 1'b1);
      chk("scope_on", 32'(scope_active), 32'h1);
      step(11'd3,    10'd3, 1'b0, 1'b1, 12'h000, "sc_ctr");
      step(11'd4,    10'd3, 1'b0, 1'b1, 12'h5A5, "sc_gap");
      step(11'd5,    10'd3, 1'b0, 1'b1, 12'h000, "sc_r5");
      step(11'd6,    10'd3, 1'b0, 1'b1, 12'h000, "sc_r6");
      step(11'd7,    10'd3, 1'b0, 1'b1, 12'h000, "sc_r7");
      step(11'd8,    10'd3, 1'b0, 1'b1, 12'h5A5, "sc_r8");
      step(11'd2,    10'd3, 1'b0, 1'b1, 12'h5A5, "sc_lgap");
      step(11'd1,    10'd3, 1'b0, 1'b1, 12'h000, "sc_l1");
      step(11'd0,    10'd3, 1'b0, 1'b1, 12'h000, "sc_l0");
      step(11'd3,    10'd0, 1'b0, 1'b1, 12'h000, "sc_up");
      step(11'd3,    10'd4, 1'b0, 1'b1, 12'h5A5, "sc_dgap");
      step(11'd3,    10'd5, 1'b0, 1'b1, 12'h000, "sc_down");
      step(11'd4,    10'd4, 1'b0, 1'b1, 12'h5A5, "sc_diag");
      step(11'd2047, 10'd3, 1'b0, 1'b1, 12'h5A5, "sc_edge0");
      step(11'd2046, 10'd3, 1'b0, 1'b1, 12'h5A5, "sc_edge1");
      step(11'd2045, 10'd3, 1'b0, 1'b1, 12'h5A5, "sc_edge2");
      flush();

      // reset mid-line while in SCOPE
      step(11'd500, 10'd3, 1'b0, 1'b0, 12'h0, "");
      rst = 1'b0;
      step(11'd501, 10'd3, 1'b0, 1'b0, 12'h0, "");
      chk("mid_rst_rgb", 32'(rgb_out), 32'h0);
      chk("mid_rst_hc", 32'(hcount_out), 32'h0);
      chk("mid_rst_vc", 32'(vcount_out), 32'h0);
      chk("mid_rst_tim", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
      chk("mid_rst_scope", 32'(scope_active), 32'h0);
      rst = 1'b1;
      step(11'd502, 10'd3, 1'b0, 1'b0, 12'h0, "");
      chk("refill_rgb", 32'(rgb_out), 32'h0);
      flush();
      frame(12'd3, 12'd3, 1'b1);
      chk("post_rst_arming", 32'(scope_active), 32'h0);
      step(11'd4, 10'd6, 1'b0, 1'b1, 12'hFFF, "post_rst_arrow");
      flush();

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cursor_overlay_pipe.md
Name: cursor_overlay_pipe

Overview:
- Parametrised second-generation cursor overlay in the VGA pixel chain.
- Draws an arrow cursor or a crosshair scope over incoming rgb at a mouse position.
- Position and mode change only at frame boundaries, so there is no tearing; mode switch uses frame-count hysteresis.
- Two-stage pipeline; all timing signals are delayed to match.

Parameters:
- HC_W, 11, hcount width
- VC_W, 10, vcount width
- POS_W, 12, xpos/ypos width
- RGB_W, 12, colour width
- ARROW_K, 12, arrow triangle size in pixels (rows/cols 0..ARROW_K)
- SCOPE_GAP, 1, empty pixels between centre dot and each arm
- SCOPE_ARM, 3, arm length in pixels
- SCOPE_XLIMIT, 600, scope allowed only when latched xpos < this
- HOLD_FRAMES, 2, consecutive frames the mode request must hold before switching (1..15)
- OUTLINE_RGB, 12'h000, outline/crosshair colour
- FILL_RGB, 12'hFFF, arrow fill colour

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; synchronous, active-low
- xpos  in  POS_W  mouse x
- ypos  in  POS_W  mouse y
- select_mode  in  1  scope request
- hcount  in  HC_W  pixel x
- vcount  in  VC_W  pixel y
- hsync, vsync, hblnk, vblnk  in  1 each  timing
- rgb_in  in  RGB_W  background pixel
- hcount_out  out  HC_W
- vcount_out  out  VC_W
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each
- rgb_out  out  RGB_W
- scope_active  out  1  current mode is SCOPE

Behaviour:
- Reset (rst==0 at a clk edge): every output is 0; mode = MOUSE; hold counter = 0; latched position = 0; vblnk edge detector = 0.
- Frame tick: asserted for one cycle when vblnk rises (vblnk==1 and the previous vblnk==0).
- On the frame tick:
  - xpos/ypos are captured into x_l/y_l.
  - The mode FSM advances.
  - x_l/y_l stay constant for the whole frame.
- Mode FSM:
  - States MOUSE, ARMING, SCOPE, DISARMING; updates only on frame tick. req = select_mode && (xpos < SCOPE_XLIMIT), sampled at the tick.
  - MOUSE: if req, cnt=1; go to SCOPE if HOLD_FRAMES==1, else ARMING.
  - ARMING: if !req, go to MOUSE with cnt=0. Else cnt++; go to SCOPE when cnt reaches HOLD_FRAMES.
  - SCOPE: symmetric to MOUSE, using !req, toward DISARMING.
  - DISARMING: symmetric to ARMING; a returning req goes back to SCOPE; go to MOUSE when cnt reaches HOLD_FRAMES.
  - Draw shape: ARMING draws the arrow; DISARMING draws the scope.
  - scope_active = 1 in SCOPE and DISARMING.
- Pipeline stage 1 (registered):
  - dx = hcount - x_l and dy = vcount - y_l, both signed POS_W+1 bits with zero-extended operands.
  - Also registered: rgb_in, the timing signals, and the draw mode.
  - Negative offsets never wrap, so a cursor near x=0 or y=0 must not appear at the opposite screen edge.
- Pipeline stage 2 (registered):
  - Arrow region: 0<=dx<=dy<=ARROW_K.
    - Pixel is OUTLINE if dx==0, dx==dy, or dy==ARROW_K.
    - Otherwise the pixel is FILL.
  - Scope region:
    - Centre (dx==0, dy==0) is OUTLINE.
    - dy==0 with SCOPE_GAP < |dx| <= SCOPE_GAP+SCOPE_ARM is OUTLINE.
    - dx==0 with SCOPE_GAP < |dy| <= SCOPE_GAP+SCOPE_ARM is OUTLINE.
  - Any other pixel passes through the stage-1 rgb.
- Latency:
  - rgb_out and all timing/count outputs lag their inputs by exactly 2 cycles.
  - scope_active is registered and updates 1 cycle after the tick.
- Blanking: the overlay is not gated by blanking; overlay pixels during blank are drawn as computed.
- Simultaneous events:
  - Reset has priority over the tick.
  - Position changes mid-frame are ignored until the next tick.
- Reset mid-frame: outputs are 0 for the two cycles after release while the pipeline refills.

Optional Feature:
- CURSOR_BLINK_EN defined:
  - Adds parameter BLINK_FRAMES (default 30) and a frame counter that advances on each tick.
  - A visible flag toggles whenever the counter wraps at BLINK_FRAMES-1; the flag resets to 1 with the counter at 0.
  - Blinking applies in SCOPE mode only; while the flag is 0 the scope is not drawn and rgb passes through.
  - The arrow always draws.
- CURSOR_BLINK_EN undefined: no counter; the scope is always drawn.

Test Plan:
- Arrow: reset, release, tick with xpos=100, ypos=50, select_mode=0; rgb_in=12'h5A5 everywhere.
  - (100,50) -> 12'h000; (105,60) -> 12'hFFF; (100+12,62) -> 12'h000; (99,50) -> 12'h5A5.
  - Each value appears 2 cycles after the matching hcount.
- Hysteresis (HOLD_FRAMES=2): select_mode=1, xpos=300.
  - scope_active is 0 after tick 1 and 1 after tick 2.
  - Drop req for one frame, then restore it: stays SCOPE.
- X limit: select_mode=1, xpos=700 for 5 frames -> scope_active stays 0, arrow drawn.
- Scope shape (GAP=1, ARM=3), centre (3,3) at the screen corner:
  - (3,3), (5..7,3), (0,3) are 12'h000; (4,3) passes rgb_in.
  - No OUTLINE pixel at hcount 2047-derived positions near the right edge.
- Mid-frame move: change xpos from 100 to 400 while vblnk=0 -> cursor stays at 100 until the next tick, then appears at 400.
- Reset: drive rst=0 mid-line -> next cycle all outputs 0 and mode MOUSE.
  - With CURSOR_BLINK_EN and BLINK_FRAMES=2: scope is visible for 2 frames, then hidden for 2.
